// File: rtl/cache_arbiter_pkg.sv
// Shared types for the I/D cacheline arbiter: FSM states, latched op
// and the line-offset helper used to align the memory address.
package arbiter_types;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D,
    RESP
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

  // Byte-offset bits inside one cacheline.
  function automatic int line_off_bits(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  localparam int LINE_OFF_BITS = line_off_bits(256);

endpackage

// File: rtl/cache_arbiter_grant.sv
// Winner selection in IDLE plus the D-grant streak counter.
// Ports: clk, rst (sync, active-low), en (FSM in IDLE), i_read,
// d_read, d_write in; grant_i, grant_d (one-hot) out.
module arbiter_grant #(
  parameter int MAX_D_STREAK = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic i_read,
  input  logic d_read,
  input  logic d_write,
  output logic grant_i,
  output logic grant_d
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);

  logic [SW-1:0] streak;
  logic          d_req;
  logic          at_max;

  assign d_req  = d_read | d_write;
  assign at_max = (streak == SW'(MAX_D_STREAK));

  // D wins unless I has waited through a full streak of D grants.
  assign grant_d = en & d_req & ~(i_read & at_max);
  assign grant_i = en & i_read & ~grant_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak <= '0;
    end else if (grant_i) begin
      streak <= '0;
    end else if (grant_d) begin
      if (!i_read)
        streak <= '0;
      else if (!at_max)
        streak <= streak + SW'(1);
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache.
// Ports: clk, rst (sync, active-low); i_read/i_address -> i_rdata/i_resp;
// d_read/d_write/d_address/d_wdata -> d_rdata/d_resp; pmem_* memory side.
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH   = 256,
  parameter int ADDR_WIDTH   = 32,
  parameter int MAX_D_STREAK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int OFF = line_off_bits(LINE_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK =
    ~ADDR_WIDTH'((1 << OFF) - 1);

  arb_state_t            state, state_n;
  arb_op_t               op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  idle;
  logic                  grant_i, grant_d;

  assign idle = (state == IDLE);

  arbiter_grant #(
    .MAX_D_STREAK(MAX_D_STREAK)
  ) u_grant (
    .clk     (clk),
    .rst     (rst),
    .en      (idle),
    .i_read  (i_read),
    .d_read  (d_read),
    .d_write (d_write),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (grant_d)
          state_n = SERVE_D;
        else if (grant_i)
          state_n = SERVE_I;
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp)
          state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Strobes depend only on registered state, never on requester inputs.
  assign pmem_read = (state == SERVE_I) |
                     ((state == SERVE_D) & (op_q == OP_READ));
  assign pmem_write   = (state == SERVE_D) & (op_q == OP_WRITE);
  assign pmem_address = addr_q & ALIGN_MASK;
  assign pmem_wdata   = wdata_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      op_q    <= OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      i_rdata <= '0;
      d_rdata <= '0;
      i_resp  <= 1'b0;
      d_resp  <= 1'b0;
    end else begin
      state  <= state_n;
      i_resp <= 1'b0;
      d_resp <= 1'b0;
      if (grant_d) begin
        addr_q  <= d_address;
        wdata_q <= d_wdata;
        op_q    <= d_write ? OP_WRITE : OP_READ;
      end else if (grant_i) begin
        addr_q <= i_address;
        op_q   <= OP_READ;
      end
      // Resp flops go high exactly in the RESP cycle.
      if (state == SERVE_I && pmem_resp) begin
        i_rdata <= pmem_rdata;
        i_resp  <= 1'b1;
      end
      if (state == SERVE_D && pmem_resp) begin
        d_resp <= 1'b1;
        if (op_q == OP_READ)
          d_rdata <= pmem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a fixed-latency memory model.
// Checks reset, lone I/D traffic, priority, streak bound, abort, rd+wr.
module tb_cache_arbiter;
  import arbiter_types::*;

  localparam int LW  = 256;
  localparam int AW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp;
  logic          mem_resp = 1'b0;
  logic          stray = 1'b0;
  int            mcnt = 0;

  int n_checks = 0;
  int n_errors = 0;

  int  rd_cyc, wr_cyc, rd_rise, both_hi, ni, nd;
  bit  rd_prev;
  byte log_q[$];

  cache_arbiter #(
    .LINE_WIDTH(LW),
    .ADDR_WIDTH(AW),
    .MAX_D_STREAK(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] line_of(input logic [AW-1:0] a);
    logic [LW-1:0] r;
    for (int k = 0; k < 8; k++)
      r[k*32 +: 32] = a ^ (32'h1111_1111 * (k + 1));
    return r;
  endfunction

  // Memory answers LAT cycles after the strobe first appears.
  assign pmem_resp = mem_resp | stray;

  always @(negedge clk) begin
    if (!rst) begin
      mcnt     = 0;
      mem_resp = 1'b0;
    end else if (pmem_read || pmem_write) begin
      mcnt++;
      mem_resp = (mcnt == LAT);
    end else begin
      mcnt     = 0;
      mem_resp = 1'b0;
    end
    pmem_rdata = line_of(pmem_address);
  end

  task automatic chk(input string tag,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic clr();
    rd_cyc  = 0;
    wr_cyc  = 0;
    rd_rise = 0;
    both_hi = 0;
    ni      = 0;
    nd      = 0;
    rd_prev = 1'b0;
    log_q.delete();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (pmem_read) rd_cyc++;
    if (pmem_write) wr_cyc++;
    if (pmem_read && !rd_prev) rd_rise++;
    if (pmem_read && pmem_write) both_hi++;
    rd_prev = pmem_read;
    if (d_resp) begin
      nd++;
      log_q.push_back("D");
    end
    if (i_resp) begin
      ni++;
      log_q.push_back("I");
    end
  endtask

  logic [LW-1:0] w1, w2;
  byte           exp_seq [10];
  int            cyc;

  initial begin
    w1 = {8{32'hDEAD_BEEF}};
    w2 = {4{64'h0123_4567_89AB_CDEF}};
    exp_seq = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
    clr();

    // Reset state
    step();
    step();
    chk("rst_irdata", i_rdata, '0);
    chk("rst_drdata", d_rdata, '0);
    chk("rst_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("rst_resp", {i_resp, d_resp}, 2'b00);
    rst = 1'b1;
    step();

    // 1: lone I read
    clr();
    i_read    = 1'b1;
    i_address = 32'h0000_1234;
    step();
    chk("t1_rd", pmem_read, 1'b1);
    chk("t1_wr", pmem_write, 1'b0);
    chk("t1_addr", pmem_address, 32'h0000_1220);
    cyc = 0;
    while (!i_resp && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t1_lat", cyc, LAT);
    chk("t1_data", i_rdata, line_of(32'h0000_1220));
    i_read = 1'b0;
    step();
    chk("t1_pulse", i_resp, 1'b0);
    chk("t1_counts", {ni, nd}, {32'd1, 32'd0});

    // 2: lone D write
    clr();
    d_write   = 1'b1;
    d_address = 32'h8000_00FF;
    d_wdata   = w1;
    step();
    chk("t2_wr", pmem_write, 1'b1);
    chk("t2_rd", pmem_read, 1'b0);
    chk("t2_addr", pmem_address, 32'h8000_00E0);
    chk("t2_wdata", pmem_wdata, w1);
    cyc = 0;
    while (!d_resp && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t2_lat", cyc, LAT);
    d_write = 1'b0;
    step();
    chk("t2_pulse", d_resp, 1'b0);
    chk("t2_nd", nd, 1);
    chk("t2_drdata", d_rdata, '0);

    // 3: simultaneous I and D reads
    clr();
    i_read    = 1'b1;
    i_address = 32'h0000_0100;
    d_read    = 1'b1;
    d_address = 32'h0000_0200;
    cyc = 0;
    while ((i_read || d_read) && cyc < 60) begin
      step();
      if (d_resp) d_read = 1'b0;
      if (i_resp) i_read = 1'b0;
      cyc++;
    end
    i_read = 1'b0;
    d_read = 1'b0;
    step();
    step();
    chk("t3_nresp", ni + nd, 2);
    chk("t3_first", log_q[0], "D");
    chk("t3_second", log_q[1], "I");
    chk("t3_windows", rd_rise, 2);
    chk("t3_overlap", both_hi, 0);
    chk("t3_ddata", d_rdata, line_of(32'h0000_0200));
    chk("t3_idata", i_rdata, line_of(32'h0000_0100));

    // 4: streak bound with both requesters held
    clr();
    i_read    = 1'b1;
    i_address = 32'h0000_3000;
    d_read    = 1'b1;
    d_address = 32'h0000_4000;
    cyc = 0;
    while (log_q.size() < 10 && cyc < 200) begin
      step();
      cyc++;
    end
    i_read = 1'b0;
    d_read = 1'b0;
    chk("t4_count", log_q.size(), 10);
    for (int k = 0; k < 10; k++)
      chk($sformatf("t4_seq%0d", k), log_q[k], exp_seq[k]);
    for (int k = 0; k < 6; k++)
      step();
    chk("t4_quiet", {pmem_read, pmem_write}, 2'b00);

    // 5: reset while a D write is in flight
    clr();
    d_write   = 1'b1;
    d_address = 32'h4000_0040;
    d_wdata   = w1;
    step();
    chk("t5_wr", pmem_write, 1'b1);
    rst = 1'b0;
    step();
    chk("t5_strobe", {pmem_read, pmem_write}, 2'b00);
    chk("t5_resp", {i_resp, d_resp}, 2'b00);
    chk("t5_irdata", i_rdata, '0);
    chk("t5_drdata", d_rdata, '0);
    chk("t5_state", dut.state, IDLE);
    d_write = 1'b0;
    rst     = 1'b1;
    step();
    stray = 1'b1;
    step();
    stray = 1'b0;
    step();
    step();
    chk("t5_noresp", {ni, nd}, {32'd0, 32'd0});
    chk("t5_wrcyc", wr_cyc, 1);
    chk("t5_idle", dut.state, IDLE);

    // 6: read and write together is a write
    clr();
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_0C10;
    d_wdata   = w2;
    step();
    chk("t6_wdata", pmem_wdata, w2);
    chk("t6_addr", pmem_address, 32'h0000_0C00);
    cyc = 0;
    while (!d_resp && cyc < 20) begin
      step();
      cyc++;
    end
    d_read  = 1'b0;
    d_write = 1'b0;
    step();
    step();
    chk("t6_rdcyc", rd_cyc, 0);
    chk("t6_wrcyc", wr_cyc, LAT);
    chk("t6_nd", nd, 1);
    chk("t6_drdata", d_rdata, '0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
